// File: rtl/regfile_4x24_pkg.sv
// Shared CPU package: register-file geometry, write-back/opcode encodings
// and the saturating-counter helper used by the register file.
package regfile_4x24_pkg;

  localparam int RF_WIDTH = 24;
  localparam int RF_NREG  = 4;
  localparam int RF_AW    = 2;
  localparam int RF_CNT_W = 16;

  // Write-back 4:1 source selector feeding WriteData
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  // Top-level opcode encodings of the small CPU
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_LD   = 4'd4,
    OP_ST   = 4'd5,
    OP_BEQ  = 4'd6,
    OP_JAL  = 4'd7,
    OP_LI   = 4'd8,
    OP_NOP  = 4'd15
  } opcode_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [RF_CNT_W-1:0] sat_inc16(input logic [RF_CNT_W-1:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/regfile_4x24_read_port.sv
// Combinational read port: address decode, same-cycle write bypass and
// register-0 masking. Out-of-range addresses read as zero.
module regfile_read_port
  import regfile_4x24_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int NREG    = RF_NREG,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic [WIDTH-1:0] regs [NREG],
  input  logic [RF_AW-1:0] raddr,
  input  logic             wen,
  input  logic [RF_AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic             in_range_s;
  logic             zero_hit_s;
  logic             bypass_hit_s;
  logic [WIDTH-1:0] stored_s;

  // Select stored value, then apply zero masking and bypass priority
  always_comb begin
    in_range_s = 1'b0;
    stored_s   = '0;
    for (int i = 0; i < NREG; i++) begin
      in_range_s = in_range_s | (raddr == RF_AW'(i));
      stored_s   = (raddr == RF_AW'(i)) ? regs[i] : stored_s;
    end
    zero_hit_s   = (ZERO_R0 != 0) && (raddr == '0);
    bypass_hit_s = (BYPASS != 0) && wen && (raddr == waddr);
    if (!in_range_s || zero_hit_s) begin
      rdata = '0;
    end else if (bypass_hit_s) begin
      rdata = wdata;
    end else begin
      rdata = stored_s;
    end
  end

endmodule

// File: rtl/regfile_4x24.sv
// Flip-flop register file with two combinational read ports, a registered
// debug observation port and a saturating count of performed writes.
module regfile_4x24
  import regfile_4x24_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int NREG    = RF_NREG,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                RegWrite,
  input  logic [RF_AW-1:0]    WriteAddr,
  input  logic [WIDTH-1:0]    WriteData,
  input  logic [RF_AW-1:0]    ReadAddrA,
  input  logic [RF_AW-1:0]    ReadAddrB,
  output logic [WIDTH-1:0]    ReadDataA,
  output logic [WIDTH-1:0]    ReadDataB,
  input  logic [RF_AW-1:0]    DebugAddr,
  output logic [WIDTH-1:0]    DebugData,
  output logic [RF_CNT_W-1:0] WriteCount
);

  logic [WIDTH-1:0]    regs_r [NREG];
  logic [WIDTH-1:0]    debug_r;
  logic [RF_CNT_W-1:0] count_r;

  logic                waddr_ok_s;
  logic                write_ok_s;
  logic [WIDTH-1:0]    debug_next_s;

  // Decide whether this edge really writes, and what the debug port will hold after it
  always_comb begin
    waddr_ok_s   = 1'b0;
    debug_next_s = '0;
    for (int i = 0; i < NREG; i++) begin
      waddr_ok_s   = waddr_ok_s | (WriteAddr == RF_AW'(i));
      debug_next_s = (DebugAddr == RF_AW'(i)) ? regs_r[i] : debug_next_s;
    end
    write_ok_s = RegWrite && waddr_ok_s && !((ZERO_R0 != 0) && (WriteAddr == '0));
    if (write_ok_s && (WriteAddr == DebugAddr)) begin
      debug_next_s = WriteData;
    end else begin
      debug_next_s = debug_next_s;
    end
  end

  // Register storage, debug snapshot and write counter; reset wins over writes
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
      debug_r <= '0;
      count_r <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (write_ok_s && (WriteAddr == RF_AW'(i))) begin
          regs_r[i] <= WriteData;
        end
      end
      debug_r <= debug_next_s;
      if (write_ok_s) begin
        count_r <= sat_inc16(count_r);
      end
    end
  end

  assign DebugData  = debug_r;
  assign WriteCount = count_r;

  regfile_read_port #(
    .WIDTH(WIDTH), .NREG(NREG), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
  ) u_rd_a (
    .regs (regs_r),
    .raddr(ReadAddrA),
    .wen  (RegWrite),
    .waddr(WriteAddr),
    .wdata(WriteData),
    .rdata(ReadDataA)
  );

  regfile_read_port #(
    .WIDTH(WIDTH), .NREG(NREG), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
  ) u_rd_b (
    .regs (regs_r),
    .raddr(ReadAddrB),
    .wen  (RegWrite),
    .waddr(WriteAddr),
    .wdata(WriteData),
    .rdata(ReadDataB)
  );

endmodule

// File: doc/regfile_4x24.md
REGFILE_4X24 -- requirements
Module: regfile_4x24

Interface
REQ-001 Parameter WIDTH, default 24: data width of every register and port.
REQ-002 Parameter NREG, default 4: number of registers; address width is 2 bits at default.
REQ-003 Parameter BYPASS, default 1: when 1, a read of the register being written returns the new data in the same cycle.
REQ-004 Parameter ZERO_R0, default 0: when 1, register 0 reads as zero and ignores writes.
REQ-005 Clock  input  1: single clock; all state updates on the rising edge.
REQ-006 Reset  input  1: synchronous, active-high; sampled on the rising edge of Clock.
REQ-007 RegWrite  input  1: write enable for the write-back port.
REQ-008 WriteAddr  input  2: destination register index.
REQ-009 WriteData  input  WIDTH: write-back value from the write-back 4:1 source selector.
REQ-010 ReadAddrA  input  2: operand A register index.
REQ-011 ReadAddrB  input  2: operand B register index.
REQ-012 ReadDataA  output  WIDTH: operand A value, combinational from state and inputs.
REQ-013 ReadDataB  output  WIDTH: operand B value, combinational from state and inputs.
REQ-014 DebugAddr  input  2: debug/observation register index.
REQ-015 DebugData  output  WIDTH: registered copy of register DebugAddr, updated every cycle.
REQ-016 WriteCount  output  16: number of accepted writes since reset, saturating.

Function
REQ-017 On a rising edge with RegWrite=1 and Reset=0, the register at WriteAddr SHALL take WriteData; all other registers SHALL hold.
REQ-018 With RegWrite=0, no register SHALL change.
REQ-019 ReadDataA/B SHALL equal the stored register at ReadAddrA/B with zero cycles of latency (combinational read).
REQ-020 With BYPASS=1, RegWrite=1 and ReadAddrX==WriteAddr, ReadDataX SHALL equal WriteData in the same cycle; with BYPASS=0 it SHALL show the old value until the next edge.
REQ-021 With ZERO_R0=1, reads of register 0 SHALL return 0, writes to it SHALL be dropped, and the bypass SHALL be suppressed for address 0.
REQ-022 Both read ports reading the same address SHALL return identical values, including during bypass.
REQ-023 DebugData SHALL be registered: the value is that of register DebugAddr as it stands after the same edge's write, visible one cycle later.
REQ-024 WriteCount SHALL increment by 1 on each edge where a write is actually performed (writes dropped under ZERO_R0 do not count), and SHALL saturate at 16'hFFFF.
REQ-025 Out-of-range addresses (NREG<4 only) SHALL read as 0 and ignore writes.

Reset
REQ-026 On a rising edge with Reset=1, all registers, DebugData and WriteCount SHALL become 0, overriding any simultaneous write.
REQ-027 During the Reset=1 cycle, bypass SHALL still drive ReadDataX combinationally; registers SHALL read 0 on the cycle after reset.
REQ-028 Reset asserted mid-sequence SHALL discard the pending write of that edge; no partial state remains.

Structure
REQ-029 WIDTH default, NREG default and the register-address width SHALL be defined as constants in the shared CPU package alongside the opcode/select encodings.
REQ-030 The read port (address decode + bypass + zero-R0 masking) SHALL be a sub-module regfile_read_port, instantiated twice (A, B); the debug port SHALL use plain stored-value selection without bypass.
REQ-031 Storage SHALL be flip-flops; no latches and no inferred memory with registered read.

Verification
REQ-032 Reset for 1 cycle, then ReadAddrA=0..3 -> ReadDataA=0 for all registers and WriteCount=0.
REQ-033 Write 24'hABCDEF to R2, next cycle ReadAddrA=2, ReadAddrB=2 -> both return 24'hABCDEF; WriteCount=1.
REQ-034 BYPASS=1: RegWrite=1, WriteAddr=1, WriteData=24'h123456, ReadAddrA=1 in the same cycle -> ReadDataA=24'h123456 before the edge; BYPASS=0 -> the old R1 value.
REQ-035 ZERO_R0=1: write 24'hFFFFFF to R0 -> R0 reads 0, the same-cycle read of R0 returns 0, and WriteCount is unchanged.
REQ-036 Write R3=24'h00000F, then assert Reset in the same cycle as writing R3=24'h0000F0 -> R3 reads 0 afterwards and WriteCount=0.
REQ-037 Preload WriteCount to 16'hFFFE via 2 further writes from 16'hFFFC -> after 3 more writes it reads 16'hFFFF; DebugAddr=2 tracks R2 with exactly one cycle of lag.
